// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the memory-access stage.
// Holds mem_op encodings, bus/datapath widths and alignment helpers.
package mem_stage_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int MEMOP_W    = 4;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef logic [MEMOP_W-1:0] mem_op_t;

    localparam mem_op_t MEM_NONE = 4'd0;
    localparam mem_op_t MEM_LB   = 4'd1;
    localparam mem_op_t MEM_LH   = 4'd2;
    localparam mem_op_t MEM_LW   = 4'd3;
    localparam mem_op_t MEM_LBU  = 4'd4;
    localparam mem_op_t MEM_LHU  = 4'd5;
    localparam mem_op_t MEM_SB   = 4'd6;
    localparam mem_op_t MEM_SH   = 4'd7;
    localparam mem_op_t MEM_SW   = 4'd8;

    function automatic logic is_store(mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_aligned(mem_op_t op, logic [1:0] lane);
        logic ok;
        ok = 1'b1;
        unique case (1'b1)
            (op == MEM_LH), (op == MEM_LHU), (op == MEM_SH):
                ok = ~lane[0];
            (op == MEM_LW), (op == MEM_SW):
                ok = (lane == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering: store byte enables/replication and load extract/extend.
// Ports: st_op/st_lane/st_data -> be/wdata; ld_op/ld_lane/rdata -> ldata.
module mem_stage_align
    import mem_stage_pkg::*;
(
    input  mem_op_t           st_op,
    input  logic [1:0]        st_lane,
    input  logic [DATA_W-1:0] st_data,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata,
    input  mem_op_t           ld_op,
    input  logic [1:0]        ld_lane,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ldata
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        unique case (1'b1)
            (st_op == MEM_SB): begin
                be    = 4'b0001 << st_lane;
                wdata = {4{st_data[7:0]}};
            end
            (st_op == MEM_SH): begin
                be    = 4'b0011 << st_lane;
                wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Move the addressed lane down to bit 0 before extending.
    assign shifted = rdata >> {ld_lane, 3'b000};

    always_comb begin
        ldata = rdata;
        unique case (1'b1)
            (ld_op == MEM_LB):  ldata = {{24{shifted[7]}}, shifted[7:0]};
            (ld_op == MEM_LBU): ldata = {24'b0, shifted[7:0]};
            (ld_op == MEM_LH):  ldata = {{16{shifted[15]}}, shifted[15:0]};
            (ld_op == MEM_LHU): ldata = {16'b0, shifted[15:0]};
            default:            ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: ALU ops pass through in one cycle, loads/stores run
// a req/gnt/rvalid bus transaction. Ports: exe_mem inputs, stall_o, dbus_*, mem_wb outputs.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int RADDR_WIDTH = REG_ADDR_W,
    parameter int RDATA_WIDTH = DATA_W,
    parameter int MEMOP_WIDTH = MEMOP_W
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   valid_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
    input  logic [MEMOP_WIDTH-1:0] mem_op_i,
    input  logic [RDATA_WIDTH-1:0] store_data_i,
    output logic                   stall_o,
    output logic                   dbus_req_o,
    output logic                   dbus_we_o,
    output logic [RDATA_WIDTH-1:0] dbus_addr_o,
    output logic [3:0]             dbus_be_o,
    output logic [RDATA_WIDTH-1:0] dbus_wdata_o,
    input  logic                   dbus_gnt_i,
    input  logic                   dbus_rvalid_i,
    input  logic [RDATA_WIDTH-1:0] dbus_rdata_i,
    output logic                   valid_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [RDATA_WIDTH-1:0] reg_wdata_o,
    output logic                   misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state_q, state_d;

    logic                   is_mem;
    logic                   aligned;
    logic                   issue;
    logic                   wb_we;
    logic [3:0]             st_be;
    logic [RDATA_WIDTH-1:0] st_wdata;
    logic [RDATA_WIDTH-1:0] ld_data;

    // Transaction context captured at issue.
    mem_op_t                op_q;
    logic [RDATA_WIDTH-1:0] addr_q;
    logic [RADDR_WIDTH-1:0] waddr_q;
    logic                   we_q;

    assign is_mem  = (mem_op_i != MEM_NONE);
    assign aligned = is_aligned(mem_op_i, reg_wdata_i[1:0]);
    assign issue   = (state_q == IDLE) & valid_i & is_mem & aligned;
    assign wb_we   = reg_we_i & (reg_waddr_i != RADDR_WIDTH'(ZERO_REG));

    // Released in the rvalid cycle so the next instruction enters next edge.
    assign stall_o = issue
                   | (state_q == REQ)
                   | ((state_q == RESP) & ~dbus_rvalid_i);

    mem_stage_align u_align (
        .st_op   (mem_op_i),
        .st_lane (reg_wdata_i[1:0]),
        .st_data (store_data_i),
        .be      (st_be),
        .wdata   (st_wdata),
        .ld_op   (op_q),
        .ld_lane (addr_q[1:0]),
        .rdata   (dbus_rdata_i),
        .ldata   (ld_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (issue)         state_d = REQ;
            REQ:     if (dbus_gnt_i)    state_d = RESP;
            RESP:    if (dbus_rvalid_i) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_be_o    <= '0;
            dbus_wdata_o <= '0;
            valid_o      <= 1'b0;
            misalign_o   <= 1'b0;
            reg_waddr_o  <= RADDR_WIDTH'(ZERO_REG);
            reg_we_o     <= 1'b0;
            reg_wdata_o  <= '0;
            op_q         <= MEM_NONE;
            addr_q       <= '0;
            waddr_q      <= '0;
            we_q         <= 1'b0;
        end else begin
            valid_o    <= 1'b0;
            misalign_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (valid_i && !is_mem) begin
                        valid_o     <= 1'b1;
                        reg_waddr_o <= reg_waddr_i;
                        reg_we_o    <= wb_we;
                        reg_wdata_o <= reg_wdata_i;
                    end else if (valid_i && !aligned) begin
                        valid_o     <= 1'b1;
                        misalign_o  <= 1'b1;
                        reg_waddr_o <= reg_waddr_i;
                        reg_we_o    <= 1'b0;
                        reg_wdata_o <= reg_wdata_i;
                    end else if (issue) begin
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= is_store(mem_op_i);
                        dbus_addr_o  <= {reg_wdata_i[RDATA_WIDTH-1:2], 2'b00};
                        dbus_be_o    <= st_be;
                        dbus_wdata_o <= st_wdata;
                        op_q         <= mem_op_i;
                        addr_q       <= reg_wdata_i;
                        waddr_q      <= reg_waddr_i;
                        we_q         <= wb_we & ~is_store(mem_op_i);
                    end
                end
                REQ: begin
                    if (dbus_gnt_i) dbus_req_o <= 1'b0;
                end
                RESP: begin
                    if (dbus_rvalid_i) begin
                        valid_o     <= 1'b1;
                        reg_waddr_o <= waddr_q;
                        reg_we_o    <= we_q;
                        reg_wdata_o <= is_store(op_q) ? addr_q : ld_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
